// File: rtl/hex_display_ctrl_if.sv
// Avalon-MM slave bus carrying register accesses into the hex display controller.
interface hex_display_ctrl_if;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address,
    output write,
    output writedata,
    output read,
    input  readdata,
    input  readdatavalid
  );

  modport slave (
    input  address,
    input  write,
    input  writedata,
    input  read,
    output readdata,
    output readdatavalid
  );
endinterface

// File: rtl/hex_display_ctrl.sv
// Seven-segment display controller: shadow/commit registers, hex decode,
// leading-zero suppression and per-digit blinking on a 1 ms time base.
module hex_display_ctrl #(
  parameter int unsigned NUM_DIGITS     = 6,
  parameter int unsigned CLK_HZ         = 50000000,
  parameter int unsigned BLINK_HALF_RST = 500
) (
  input  logic                    clk,
  input  logic                    reset_n,
  hex_display_ctrl_if.slave       bus,
  output logic [7*NUM_DIGITS-1:0] seg,
  output logic                    blink_phase
);

  localparam int unsigned VW       = 4 * NUM_DIGITS;
  localparam int unsigned SW       = 7 * NUM_DIGITS;
  localparam int unsigned PRESC    = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam int unsigned PW       = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int unsigned DW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BHW      = 16;

  localparam logic [1:0] ADDR_VALUE  = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_BLINK  = 2'd2;
  localparam logic [1:0] ADDR_COMMIT = 2'd3;

  typedef struct packed {
    logic [NUM_DIGITS-1:0] mask;
    logic                  lzs;
    logic                  en;
  } ctrl_t;

  // Shadow and active register banks
  logic [VW-1:0]  value_sh_q,  value_sh_d;
  logic [VW-1:0]  value_act_q, value_act_d;
  ctrl_t          ctrl_sh_q,   ctrl_sh_d;
  ctrl_t          ctrl_act_q,  ctrl_act_d;
  logic [BHW-1:0] blink_half_q, blink_half_d;

  // Blink time base
  logic [PW-1:0]  presc_q, presc_d;
  logic [BHW-1:0] ms_q,    ms_d;
  logic           phase_q, phase_d;
  logic           ms_tick_c;

  // Outputs
  logic [SW-1:0]  seg_q,   seg_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           rvalid_q, rvalid_d;

  logic [31:0]    rd_mux_c;
  logic           pending_c;
  logic           bh_wr_c;
  logic [DW-1:0]  msnz_c;
  logic           unused_wdata_c;

  assign unused_wdata_c = ^bus.writedata;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0:    code = 7'b1000000;
      4'h1:    code = 7'b1111001;
      4'h2:    code = 7'b0100100;
      4'h3:    code = 7'b0110000;
      4'h4:    code = 7'b0011001;
      4'h5:    code = 7'b0010010;
      4'h6:    code = 7'b0000010;
      4'h7:    code = 7'b1111000;
      4'h8:    code = 7'b0000000;
      4'h9:    code = 7'b0010000;
      4'hA:    code = 7'b0001000;
      4'hB:    code = 7'b0000011;
      4'hC:    code = 7'b1000110;
      4'hD:    code = 7'b0100001;
      4'hE:    code = 7'b0000110;
      default: code = 7'b0001110;
    endcase
    return code;
  endfunction

  assign bh_wr_c   = bus.write && (bus.address == ADDR_BLINK);
  assign pending_c = (value_sh_q != value_act_q) || (ctrl_sh_q != ctrl_act_q);

  // Register writes and commit
  always_comb begin
    value_sh_d   = value_sh_q;
    value_act_d  = value_act_q;
    ctrl_sh_d    = ctrl_sh_q;
    ctrl_act_d   = ctrl_act_q;
    blink_half_d = blink_half_q;
    if (bus.write) begin
      case (bus.address)
        ADDR_VALUE: value_sh_d = bus.writedata[VW-1:0];
        ADDR_CTRL: begin
          ctrl_sh_d.en   = bus.writedata[0];
          ctrl_sh_d.lzs  = bus.writedata[1];
          ctrl_sh_d.mask = bus.writedata[8 +: NUM_DIGITS];
        end
        ADDR_BLINK: blink_half_d = bus.writedata[BHW-1:0];
        default: begin
          if (bus.writedata[0]) begin
            value_act_d = value_sh_q;
            ctrl_act_d  = ctrl_sh_q;
          end
        end
      endcase
    end
  end

  // 1 ms prescaler, ms counter and blink phase; a BLINK_HALF write restarts all three
  always_comb begin
    ms_tick_c = (presc_q == PW'(PRESC - 1));
    presc_d   = ms_tick_c ? '0 : presc_q + PW'(1);
    ms_d      = ms_q;
    phase_d   = phase_q;
    if (bh_wr_c) begin
      presc_d = '0;
      ms_d    = '0;
      phase_d = 1'b0;
    end else if (blink_half_q == '0) begin
      ms_d    = '0;
      phase_d = 1'b0;
    end else if (ms_tick_c) begin
      if (ms_q == blink_half_q - BHW'(1)) begin
        ms_d    = '0;
        phase_d = ~phase_q;
      end else begin
        ms_d = ms_q + BHW'(1);
      end
    end
  end

  // Most significant nonzero nibble; stays 0 for an all-zero value so digit 0 is shown
  always_comb begin
    msnz_c = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (value_act_q[4*i +: 4] != 4'd0) msnz_c = DW'(i);
    end
  end

  // Per-digit priority: enable, then leading-zero blank, then blink, then glyph
  always_comb begin
    seg_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (ctrl_act_q.en &&
          !(ctrl_act_q.lzs && (DW'(i) > msnz_c)) &&
          !(ctrl_act_q.mask[i] && phase_q)) begin
        seg_d[7*i +: 7] = hex_decode(value_act_q[4*i +: 4]);
      end
    end
  end

  always_comb begin
    case (bus.address)
      ADDR_VALUE:  rd_mux_c = 32'(value_sh_q);
      ADDR_CTRL:   rd_mux_c = 32'({ctrl_sh_q.mask, 6'b0, ctrl_sh_q.lzs, ctrl_sh_q.en});
      ADDR_BLINK:  rd_mux_c = 32'(blink_half_q);
      ADDR_COMMIT: rd_mux_c = {30'b0, phase_q, pending_c};
      default:     rd_mux_c = '0;
    endcase
    rdata_d  = bus.read ? rd_mux_c : rdata_q;
    rvalid_d = bus.read;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_sh_q   <= '0;
      value_act_q  <= '0;
      ctrl_sh_q    <= '0;
      ctrl_act_q   <= '0;
      blink_half_q <= BHW'(BLINK_HALF_RST);
      presc_q      <= '0;
      ms_q         <= '0;
      phase_q      <= 1'b0;
      seg_q        <= '1;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
    end else begin
      value_sh_q   <= value_sh_d;
      value_act_q  <= value_act_d;
      ctrl_sh_q    <= ctrl_sh_d;
      ctrl_act_q   <= ctrl_act_d;
      blink_half_q <= blink_half_d;
      presc_q      <= presc_d;
      ms_q         <= ms_d;
      phase_q      <= phase_d;
      seg_q        <= seg_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
    end
  end

  assign seg               = seg_q;
  assign blink_phase       = phase_q;
  assign bus.readdata      = rdata_q;
  assign bus.readdatavalid = rvalid_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed and randomized checks of hex_display_ctrl against a cycle-count
// based behavioural model (1 ms tick every 4 cycles).
module tb_hex_display_ctrl;

  localparam int unsigned ND = 6;
  localparam int unsigned TPM = 4;  // clocks per ms tick at CLK_HZ=4000

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [7*ND-1:0] seg;
  logic          blink_phase;

  hex_display_ctrl_if bus ();

  hex_display_ctrl #(
    .NUM_DIGITS     (ND),
    .CLK_HZ         (4000),
    .BLINK_HALF_RST (500)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus.slave),
    .seg         (seg),
    .blink_phase (blink_phase)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Lit segments for each hex glyph, a..g
  string lit_tab [0:15] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                            "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  // Reference model state
  int unsigned m_sh_val, m_act_val, m_sh_mask, m_act_mask, m_bh, m_n;
  bit          m_sh_en, m_sh_lzs, m_act_en, m_act_lzs;
  logic [7*ND-1:0] m_seg;
  logic [31:0] m_rd;
  bit          m_rdv;

  function automatic logic [6:0] glyph(input int unsigned d);
    logic [6:0] code = 7'h7f;
    string s = lit_tab[d];
    for (int k = 0; k < s.len(); k++) begin
      int idx = int'(s[k]) - 97;
      code[idx] = 1'b0;
    end
    return code;
  endfunction

  // Phase after n clocks since the time base was cleared: toggles every bh ms
  function automatic bit model_phase(input int unsigned bh, input int unsigned n);
    if (bh == 0) return 1'b0;
    return ((n / (TPM * bh)) % 2) == 1;
  endfunction

  function automatic logic [7*ND-1:0] model_seg(input int unsigned val, input bit en, input bit lzs,
                                                input int unsigned mask, input bit ph);
    logic [7*ND-1:0] out;
    int unsigned sig = 1;
    int unsigned v = val >> 4;
    while (v != 0) begin
      sig++;
      v = v >> 4;
    end
    for (int i = 0; i < ND; i++) begin
      bit show;
      show = en && !(lzs && (i >= sig)) && !(((mask >> i) & 1) == 1 && ph);
      out[7*i +: 7] = show ? glyph((val >> (4*i)) & 15) : 7'h7f;
    end
    return out;
  endfunction

  function automatic logic [31:0] model_read(input int unsigned addr, input bit ph);
    bit pend;
    pend = (m_sh_val != m_act_val) || (m_sh_en != m_act_en) || (m_sh_lzs != m_act_lzs) ||
           (m_sh_mask != m_act_mask);
    case (addr)
      0:       return 32'(m_sh_val);
      1:       return 32'(m_sh_en) | (32'(m_sh_lzs) << 1) | (32'(m_sh_mask) << 8);
      2:       return 32'(m_bh);
      default: return {30'b0, ph, pend};
    endcase
  endfunction

  task automatic model_reset();
    m_sh_val = 0; m_act_val = 0; m_sh_mask = 0; m_act_mask = 0;
    m_sh_en = 0; m_sh_lzs = 0; m_act_en = 0; m_act_lzs = 0;
    m_bh = 500; m_n = 0;
    m_seg = '1; m_rd = '0; m_rdv = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: model follows the edge, outputs checked on the following falling edge
  task automatic step();
    bit ph_pre;
    @(posedge clk);
    ph_pre = model_phase(m_bh, m_n);
    if (reset_n) begin
      m_seg = model_seg(m_act_val, m_act_en, m_act_lzs, m_act_mask, ph_pre);
      m_rdv = bus.read;
      if (bus.read) m_rd = model_read(bus.address, ph_pre);
      m_n++;
      if (bus.write) begin
        case (bus.address)
          2'd0: m_sh_val = bus.writedata & 32'h00ff_ffff;
          2'd1: begin
            m_sh_en   = bus.writedata[0];
            m_sh_lzs  = bus.writedata[1];
            m_sh_mask = (bus.writedata >> 8) & 32'h3f;
          end
          2'd2: begin
            m_bh = bus.writedata & 32'hffff;
            m_n  = 0;
          end
          default: begin
            if (bus.writedata[0]) begin
              m_act_val = m_sh_val; m_act_en = m_sh_en; m_act_lzs = m_sh_lzs; m_act_mask = m_sh_mask;
            end
          end
        endcase
      end
    end
    @(negedge clk);
    chk("seg", 64'(seg), 64'(m_seg));
    chk("blink_phase", 64'(blink_phase), 64'(model_phase(m_bh, m_n)));
    chk("readdatavalid", 64'(bus.readdatavalid), 64'(m_rdv));
    if (m_rdv) chk("readdata", 64'(bus.readdata), 64'(m_rd));
  endtask

  task automatic idle();
    bus.write = 1'b0; bus.read = 1'b0; bus.address = 2'd0; bus.writedata = '0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.write = 1'b1; bus.read = 1'b0; bus.address = a; bus.writedata = d;
    step();
    idle();
  endtask

  task automatic rd(input logic [1:0] a);
    bus.write = 1'b0; bus.read = 1'b1; bus.address = a;
    step();
    idle();
  endtask

  initial begin
    logic [7*ND-1:0] exp_seg;
    idle();
    model_reset();

    // 1: reset values
    step(); step(); step();
    reset_n = 1'b1;
    chk("rst_seg", 64'(seg), 64'h3ff_ffff_ffff);
    chk("rst_phase", 64'(blink_phase), 64'd0);
    rd(2'd2);
    chk("rst_blink_half", 64'(bus.readdata), 64'd500);
    step();

    // 2: shadow writes, pending, commit latency
    wr(2'd0, 32'h0012AB);
    wr(2'd1, 32'h1);
    step();
    chk("no_commit_seg", 64'(seg), 64'h3ff_ffff_ffff);
    rd(2'd3);
    chk("pending_set", 64'(bus.readdata[0]), 64'd1);
    wr(2'd3, 32'h1);
    chk("commit_edge_seg_old", 64'(seg), 64'h3ff_ffff_ffff);
    step();
    exp_seg = {7'b1000000, 7'b1000000, 7'b1111001, 7'b0100100, 7'b0001000, 7'b0000011};
    chk("digits_0012AB", 64'(seg), 64'(exp_seg));
    rd(2'd3);
    chk("pending_clear", 64'(bus.readdata[0]), 64'd0);

    // 3: leading-zero suppression
    wr(2'd1, 32'h3);
    wr(2'd3, 32'h1);
    step();
    exp_seg = {7'h7f, 7'h7f, 7'b1111001, 7'b0100100, 7'b0001000, 7'b0000011};
    chk("lzs_0012AB", 64'(seg), 64'(exp_seg));
    wr(2'd0, 32'h0);
    wr(2'd3, 32'h1);
    step();
    exp_seg = {7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'b1000000};
    chk("lzs_zero", 64'(seg), 64'(exp_seg));

    // 4: blinking digit 0, then blinking disabled
    wr(2'd0, 32'h12AB);
    wr(2'd1, 32'h101);
    wr(2'd2, 32'd2);
    wr(2'd3, 32'h1);
    for (int i = 0; i < 40; i++) step();
    wr(2'd2, 32'd0);
    for (int i = 0; i < 16; i++) step();
    exp_seg = {7'b1000000, 7'b1000000, 7'b1111001, 7'b0100100, 7'b0001000, 7'b0000011};
    chk("blink_off_steady", 64'(seg), 64'(exp_seg));

    // 5: reset during the blank phase
    wr(2'd2, 32'd2);
    for (int i = 0; i < 100 && !model_phase(m_bh, m_n); i++) step();
    chk("blank_phase_reached", 64'(blink_phase), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_seg", 64'(seg), 64'h3ff_ffff_ffff);
    chk("async_rst_phase", 64'(blink_phase), 64'd0);
    model_reset();
    step(); step();
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) rd(2'(a));

    // 6: read and write VALUE in the same cycle
    wr(2'd0, 32'h00ABCD);
    bus.write = 1'b1; bus.read = 1'b1; bus.address = 2'd0; bus.writedata = 32'h000123;
    step();
    idle();
    chk("rw_old_value", 64'(bus.readdata), 64'h00ABCD);
    rd(2'd0);
    chk("rw_new_value", 64'(bus.readdata), 64'h000123);
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0);
    chk("value_upper_ignored", 64'(bus.readdata), 64'h00FF_FFFF);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bus.write   = ($urandom_range(0, 2) == 0);
      bus.read    = ($urandom_range(0, 1) == 1);
      bus.address = 2'($urandom_range(0, 3));
      if (bus.address == 2'd2)      bus.writedata = $urandom_range(0, 3);
      else if (bus.address == 2'd3) bus.writedata = $urandom_range(0, 1);
      else                          bus.writedata = $urandom();
      step();
    end
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
